// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD count-down/count-up timer.
package bcd_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Saturate an out-of-range BCD nibble to 9.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
  endfunction

endpackage

// File: rtl/bcd_timer_n_digit.sv
// Single BCD digit step cell: increment with carry (dir=1) or decrement with borrow (dir=0).
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               dir,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] next_digit_c,
  output logic               carry_out_c
);

  always_comb begin
    next_digit_c = digit;
    carry_out_c  = 1'b0;
    if (carry_in) begin
      if (dir) begin
        if (digit >= DIGIT_W'(9)) begin
          next_digit_c = '0;
          carry_out_c  = 1'b1;
        end else begin
          next_digit_c = digit + DIGIT_W'(1);
        end
      end else begin
        if (digit == '0) begin
          next_digit_c = DIGIT_W'(9);
          carry_out_c  = 1'b1;
        end else begin
          next_digit_c = digit - DIGIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_timer_n.sv
// Multi-digit BCD timer: loads a preset, then steps down to zero or up to the preset once per tick interval.
module bcd_timer_n
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  dir,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  tick
);

  localparam int unsigned COUNT_W = DIGIT_W * DIGITS;
  localparam int unsigned PRESC_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   target_q, target_d;
  logic                 dir_q, dir_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic                 running_q, done_q;

  logic [COUNT_W-1:0]   preset_clamped_c;
  logic [COUNT_W-1:0]   count_step_c;
  logic [DIGITS:0]      carry_c;

  // Clamp each preset nibble to a legal BCD digit.
  always_comb begin
    preset_clamped_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      preset_clamped_c[i*DIGIT_W +: DIGIT_W] = clamp_digit(preset[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Ripple chain of digit cells; digit 0 always receives the step request.
  assign carry_c[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit        (count_q[g*DIGIT_W +: DIGIT_W]),
      .dir          (dir_q),
      .carry_in     (carry_c[g]),
      .next_digit_c (count_step_c[g*DIGIT_W +: DIGIT_W]),
      .carry_out_c  (carry_c[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      target_q  <= '0;
      dir_q     <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  // Next-state: load overrides everything; a start onto an already-reached target skips RUN.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    if (load) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      dir_d    = dir;
      count_d  = dir ? '0 : preset_clamped_c;
      target_d = dir ? preset_clamped_c : '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (start) begin
            state_d = (count_q == target_q) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            count_d = count_step_c;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if ((presc_q == PRESC_LAST) && (count_step_c == target_q)) begin
            state_d = ST_DONE;
          end else if (pause && !start) begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_bcd_timer_n.sv
// Directed bench for bcd_timer_n with DIGITS=2, TICK_CYCLES=4.
module tb_bcd_timer_n;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       start;
  logic       pause;
  logic       dir;
  logic [7:0] preset;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       tick;

  int vectors;
  int miscompares;

  bcd_timer_n #(
    .DIGITS      (2),
    .TICK_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .dir     (dir),
    .preset  (preset),
    .count   (count),
    .running (running),
    .done    (done),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       s;
    logic       p;
    logic       d;
    logic [7:0] pr;
    logic [7:0] ec;
    logic       er;
    logic       ed;
    logic       et;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic l, input logic s, input logic p, input logic d, input logic [7:0] pr);
    load = l; start = s; pause = p; dir = d; preset = pr;
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    load = 1'b0; start = 1'b0; pause = 1'b0; dir = 1'b0; preset = 8'h00;

    //            l     s     p     d     pr     ec     er    ed    et
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h95, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset values while rst_n is held low.
    @(negedge clk);
    @(negedge clk);
    chk("reset_count", count, 8'h00);
    chk("reset_running", {7'd0, running}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_tick", {7'd0, tick}, 8'd0);
    rst_n = 1'b1;
    repeat (3) idle();
    chk("post_reset_idle_running", {7'd0, running}, 8'd0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].pr);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      chk($sformatf("tbl%0d_running", i), {7'd0, running}, {7'd0, tbl[i].er});
      chk($sformatf("tbl%0d_done", i), {7'd0, done}, {7'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_tick", i), {7'd0, tick}, {7'd0, tbl[i].et});
    end

    // Full count-down from 12 with borrow at 10 -> 09.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 56; k++) begin
      idle();
      chk($sformatf("down_k%0d_count", k), count, to_bcd((k >= 48) ? 0 : 12 - k / 4));
      chk($sformatf("down_k%0d_tick", k), {7'd0, tick}, {7'd0, (k % 4 == 0) && (k <= 48)});
      chk($sformatf("down_k%0d_done", k), {7'd0, done}, {7'd0, k >= 48});
    end

    // Count-up to preset 10, carry from 09 to 10.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    chk("up_load_count", count, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 52; k++) begin
      idle();
      chk($sformatf("up_k%0d_count", k), count, to_bcd((k >= 40) ? 10 : k / 4));
      chk($sformatf("up_k%0d_tick", k), {7'd0, tick}, {7'd0, (k % 4 == 0) && (k <= 40)});
      chk($sformatf("up_k%0d_done", k), {7'd0, done}, {7'd0, k >= 40});
      chk($sformatf("up_k%0d_running", k), {7'd0, running}, {7'd0, k < 40});
    end

    // Pause two cycles into an interval, then resume keeps the partial interval.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) idle();
    idle();
    chk("pause_first_tick", {7'd0, tick}, 8'd1);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("pause_running", {7'd0, running}, 8'd0);
    for (int k = 0; k < 20; k++) begin
      idle();
      chk($sformatf("paused_k%0d_count", k), count, 8'h11);
      chk($sformatf("paused_k%0d_tick", k), {7'd0, tick}, 8'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("resume_running", {7'd0, running}, 8'd1);
    chk("resume_tick0", {7'd0, tick}, 8'd0);
    idle();
    chk("resume_tick1", {7'd0, tick}, 8'd0);
    idle();
    chk("resume_tick2", {7'd0, tick}, 8'd1);
    chk("resume_count", count, 8'h10);

    // Load and start together: stays in IDLE, no ticks.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
    for (int k = 0; k < 12; k++) begin
      idle();
      chk($sformatf("ldst_k%0d_tick", k), {7'd0, tick}, 8'd0);
      chk($sformatf("ldst_k%0d_running", k), {7'd0, running}, 8'd0);
    end
    chk("ldst_count", count, 8'h12);

    // Asynchronous reset in RUN while tick is high.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (4) idle();
    chk("prereset_tick", {7'd0, tick}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 8'h00);
    chk("async_running", {7'd0, running}, 8'd0);
    chk("async_done", {7'd0, done}, 8'd0);
    chk("async_tick", {7'd0, tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      idle();
      chk($sformatf("postrst_k%0d_tick", k), {7'd0, tick}, 8'd0);
      chk($sformatf("postrst_k%0d_running", k), {7'd0, running}, 8'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("postrst_start_done", {7'd0, done}, 8'd1);
    chk("postrst_start_tick", {7'd0, tick}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
